// File: rtl/memcpy_engine.sv
// Background word-copy engine driving data-memory port 2; retries writes lost to port-1 collisions.
// Optional MEMCPY_OVERLAP_EN: copies overlapping dst>src ranges backward (memmove semantics).
module memcpy_engine #(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len_bytes,
  input  logic              core_we1,
  input  logic [31:0]       mem_rd2,
  output logic [ADDR_W-1:0] mem_a2,
  output logic              mem_we2,
  output logic [31:0]       mem_wd2,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic [ADDR_W-1:0] rem;
  logic [31:0]       data_buf;
  logic              backward;
  logic              err_reg;

  logic              misaligned;
  logic              out_of_range;
  logic              overlap;
  logic [ADDR_W:0]   src_end_w;
  logic [ADDR_W:0]   dst_end_w;
`ifdef MEMCPY_OVERLAP_EN
  logic [ADDR_W:0]   src_end_b;
`endif

  // Word-index end points are formed one bit wider so a huge length cannot wrap past the check.
  always_comb begin
    misaligned   = |{src_addr[1:0], dst_addr[1:0], len_bytes[1:0]};
    src_end_w    = {3'b000, src_addr[ADDR_W-1:2]} + {3'b000, len_bytes[ADDR_W-1:2]};
    dst_end_w    = {3'b000, dst_addr[ADDR_W-1:2]} + {3'b000, len_bytes[ADDR_W-1:2]};
    out_of_range = (src_end_w > (ADDR_W+1)'(MEM_WORDS)) || (dst_end_w > (ADDR_W+1)'(MEM_WORDS));
`ifdef MEMCPY_OVERLAP_EN
    src_end_b    = {1'b0, src_addr} + {1'b0, len_bytes};
    overlap      = (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end_b);
`else
    overlap      = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cur_src  <= '0;
      cur_dst  <= '0;
      rem      <= '0;
      data_buf <= '0;
      backward <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_reg  <= 1'b0;
            rem      <= len_bytes;
            backward <= overlap;
            if (overlap) begin
              cur_src <= src_addr + len_bytes - ADDR_W'(4);
              cur_dst <= dst_addr + len_bytes - ADDR_W'(4);
            end else begin
              cur_src <= src_addr;
              cur_dst <= dst_addr;
            end
            if (misaligned || out_of_range) begin
              err_reg <= 1'b1;
            end else if (len_bytes == '0) begin
              state <= DONE;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          data_buf <= mem_rd2;
          state    <= WR;
        end
        WR: begin
          // A simultaneous port-1 write discards ours, so hold everything and write again.
          if (!core_we1) begin
            cur_src <= backward ? cur_src - ADDR_W'(4) : cur_src + ADDR_W'(4);
            cur_dst <= backward ? cur_dst - ADDR_W'(4) : cur_dst + ADDR_W'(4);
            rem     <= rem - ADDR_W'(4);
            state   <= (rem == ADDR_W'(4)) ? DONE : RD;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state == RD) || (state == WR);
    done    = (state == DONE);
    mem_we2 = (state == WR);
    mem_a2  = (state == RD) ? cur_src : ((state == WR) ? cur_dst : '0);
    mem_wd2 = (state == WR) ? data_buf : 32'h0;
    err     = err_reg;
  end

endmodule

// File: tb/tb_memcpy_engine.sv
// Self-checking bench for memcpy_engine: directed cases plus randomized copies against a memmove/forward-copy model.
module tb_memcpy_engine;
  localparam int MW = 64;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr, len_bytes;
  logic          core_we1;
  logic [31:0]   mem_rd2;
  logic [AW-1:0] mem_a2;
  logic          mem_we2;
  logic [31:0]   mem_wd2;
  logic          busy, done, err;

  always #5 clk = ~clk;

  memcpy_engine #(.MEM_WORDS(MW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_bytes(len_bytes),
    .core_we1(core_we1), .mem_rd2(mem_rd2), .mem_a2(mem_a2),
    .mem_we2(mem_we2), .mem_wd2(mem_wd2),
    .busy(busy), .done(done), .err(err)
  );

  // Data memory: port 2 reads combinationally, writes on the edge unless port 1 writes too.
  logic [31:0] mem [MW];
  logic [31:0] img [MW];
  logic        load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < MW; i++) mem[i] <= img[i];
    end else if (mem_we2 && !core_we1 && (mem_a2 < 32'(MW * 4))) begin
      mem[mem_a2[7:2]] <= mem_wd2;
    end
  end
  assign mem_rd2 = (mem_a2 < 32'(MW * 4)) ? mem[mem_a2[7:2]] : 32'hDEAD_BEEF;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  logic [31:0] snap [MW];
  logic [31:0] refm [MW];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_img();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Reference: with overlap support the result is a memmove (copy from a snapshot);
  // without it, a word-by-word ascending copy that can smear overlapping data.
  task automatic model_copy(input int s, input int d, input int n);
    for (int i = 0; i < MW; i++) refm[i] = snap[i];
`ifdef MEMCPY_OVERLAP_EN
    for (int i = 0; i < n; i++) refm[d + i] = snap[s + i];
`else
    for (int i = 0; i < n; i++) refm[d + i] = refm[s + i];
`endif
  endtask

  function automatic int mem_diffs();
    int c = 0;
    for (int i = 0; i < MW; i++) if (mem[i] !== refm[i]) c++;
    return c;
  endfunction

  // mode: 0 no collisions, 1 collide on the first WR cycle only, 2 random collisions.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                          input int mode, input bit exp_err, input string tag);
    int  colls = 0, busy_cnt = 0, done_cyc = 0, n;
    bit  we_seen = 1'b0, first_hit = 1'b0;
    for (int i = 0; i < MW; i++) snap[i] = mem[i];
    @(negedge clk);
    src_addr = s; dst_addr = d; len_bytes = l; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start    = 1'b0;
      core_we1 = 1'b0;
      if (k == 1) check({tag, "_err"}, 32'(err), 32'(exp_err));
      if (mem_we2) begin
        we_seen = 1'b1;
        if ((mode == 1 && !first_hit) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
          core_we1 = 1'b1;
          colls++;
        end
        first_hit = 1'b1;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = k;
        break;
      end
      if (exp_err && k == 4) break;
    end
    @(negedge clk);
    core_we1 = 1'b0;
    n = int'(l >> 2);
    if (exp_err) begin
      for (int i = 0; i < MW; i++) refm[i] = snap[i];
      check({tag, "_we2_seen"}, 32'(we_seen), 32'(0));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(0));
      check({tag, "_done_cycle"}, 32'(done_cyc), 32'(0));
      check({tag, "_err_sticky"}, 32'(err), 32'(1));
    end else begin
      model_copy(int'(s >> 2), int'(d >> 2), n);
      check({tag, "_done_cycle"}, 32'(done_cyc), 32'((n == 0) ? 1 : 2 * n + 1 + colls));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(2 * n + colls));
      check({tag, "_done_one_cycle"}, 32'(done), 32'(0));
      check({tag, "_busy_after"}, 32'(busy), 32'(0));
    end
    check({tag, "_mem_diffs"}, 32'(mem_diffs()), 32'(0));
    $display("copy %-12s src=0x%0h dst=0x%0h len=%0d colls=%0d done_cycle=%0d err=%0b",
             tag, s, d, l, colls, done_cyc, err);
  endtask

  initial begin
    int n, s, d;
    reset = 1'b1; start = 1'b0; core_we1 = 1'b0;
    src_addr = '0; dst_addr = '0; len_bytes = '0;
    for (int i = 0; i < MW; i++) img[i] = $urandom;
    load_img();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_we2", 32'(mem_we2), 32'(0));
    check("rst_a2", mem_a2, 32'(0));
    check("rst_wd2", mem_wd2, 32'(0));
    reset = 1'b0;

    img[0] = 11; img[1] = 22; img[2] = 33; img[3] = 44;
    load_img();
    run_copy(32'h0, 32'h40, 16, 0, 1'b0, "basic");
    check("basic_w16", mem[16], 32'd11);
    check("basic_w19", mem[19], 32'd44);

    run_copy(32'h2, 32'h40, 8, 0, 1'b1, "misaligned");
    run_copy(32'h0, 32'h80, 8, 0, 1'b0, "clear_err");
    run_copy(32'hF8, 32'h0, 16, 0, 1'b1, "range_src");
    run_copy(32'h0, 32'hF4, 16, 0, 1'b1, "range_dst");
    run_copy(32'h0, 32'h0, 32'hFFFF_FFFC, 0, 1'b1, "huge_len");
    run_copy(32'hF0, 32'h0, 16, 0, 1'b0, "range_edge");
    run_copy(32'h10, 32'h20, 0, 0, 1'b0, "zero_len");
    run_copy(32'h20, 32'h60, 8, 1, 1'b0, "collide");

    img[0] = 1; img[1] = 2; img[2] = 3; img[3] = 4;
    load_img();
    run_copy(32'h0, 32'h4, 16, 0, 1'b0, "overlap");
`ifdef MEMCPY_OVERLAP_EN
    check("overlap_w4", mem[4], 32'd4);
`else
    check("overlap_w4", mem[4], 32'd1);
`endif

    // Reset during the third busy cycle of a 4-word copy: first word written, rest untouched.
    for (int i = 0; i < MW; i++) img[i] = $urandom;
    load_img();
    for (int i = 0; i < MW; i++) snap[i] = mem[i];
    @(negedge clk);
    src_addr = 32'h0; dst_addr = 32'h80; len_bytes = 16; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_we2", 32'(mem_we2), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    reset = 1'b0;
    begin
      bit activity = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (done || mem_we2 || busy) activity = 1'b1;
      end
      check("midrst_quiet", 32'(activity), 32'(0));
    end
    check("midrst_w32", mem[32], snap[0]);
    check("midrst_w33", mem[33], snap[33]);
    $display("copy %-12s reset applied in cycle 3", "midrst");
    run_copy(32'h10, 32'hA0, 12, 0, 1'b0, "after_rst");

    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(1, 8);
      s = $urandom_range(0, MW - n);
      d = $urandom_range(0, MW - n);
      run_copy(32'(s * 4), 32'(d * 4), 32'(n * 4), 2, 1'b0, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
